// File: rtl/riscv_defines.sv
// riscv_defines: shared types and constants for the instruction prefetch buffer.
package riscv_defines;
    localparam int                    WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] PC_INCR    = 32'd4;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} prefetch_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry queue of {addr,data} with flush; head is read straight from storage.
module prefetch_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fetch_entry_t             entry_i,
    output fetch_entry_t             entry_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  rd_q, wr_q;
    logic [CW-1:0]  cnt_q;

    assign entry_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: fetches instruction words ahead of the core into a FIFO; branches flush and discard old-path responses.
// Define PREFETCH_BYPASS_EN to forward a response combinationally when the queue is empty and the consumer is ready.
module if_prefetch_buffer
    import riscv_defines::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    input  logic [WORD_WIDTH-1:0] pc_start_address_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  mem_req_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic                  instr_valid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;

    prefetch_state_e       state_q, state_d;
    logic [WORD_WIDTH-1:0] fetch_addr_q, fetch_addr_d, mem_addr_q, mem_addr_d;
    logic                  mem_req_q, mem_req_d, stale_q, stale_d;
    logic [1:0]            outst_q, outst_d, discard_q, discard_d, live_d;
    logic [WORD_WIDTH-1:0] aq_q [3];
    logic [WORD_WIDTH-1:0] aq_d [3];
    logic                  gnt, rv, flush, push, pop, bypass, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count, count_d;
    fetch_entry_t          head;

    assign gnt   = mem_req_q && mem_gnt_i;
    assign rv    = mem_rvalid_i && outst_q != '0;
    assign flush = branch_i && state_q != BOOT;
`ifdef PREFETCH_BYPASS_EN
    assign bypass = rv && fifo_empty && discard_q == '0 && instr_ready_i && !flush;
`else
    assign bypass = 1'b0;
`endif
    assign push          = rv && discard_q == '0 && !flush && !bypass;
    assign pop           = !fifo_empty && instr_ready_i && !flush;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign instr_valid_o = !fifo_empty || bypass;
    assign instr_rdata_o = bypass ? mem_rdata_i : head.data;
    assign instr_addr_o  = bypass ? aq_q[0] : head.addr;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i ({aq_q[0], mem_rdata_i}),
        .entry_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A request still waiting for gnt at a branch is stale: its grant adds to the discard count, not to fetch_addr.
    always_comb begin
        outst_d   = outst_q + 2'(gnt) - 2'(rv);
        count_d   = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
        discard_d = flush ? outst_d : discard_q - 2'(rv && discard_q != '0) + 2'(gnt && stale_q);
        stale_d   = flush ? mem_req_q && !mem_gnt_i : stale_q && !gnt;
        live_d    = outst_d - discard_d;
        for (int i = 0; i < 2; i++) aq_d[i] = rv ? aq_q[i+1] : aq_q[i];
        aq_d[2] = rv ? '0 : aq_q[2];
        if (gnt) aq_d[outst_q - 2'(rv)] = mem_addr_q;
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        if (state_q == BOOT) begin
            state_d      = fetch_en_i ? RUN : BOOT;
            fetch_addr_d = fetch_en_i ? pc_start_address_i : fetch_addr_q;
        end else begin
            if (gnt && !stale_q) fetch_addr_d = fetch_addr_q + PC_INCR;
            if (flush) fetch_addr_d = branch_addr_i & ~32'h3;
            if (state_q == RUN && !fetch_en_i && !mem_req_q) state_d = HOLD;
            if (state_q == HOLD && fetch_en_i) state_d = RUN;
        end
        mem_req_d  = mem_req_q && !mem_gnt_i;
        mem_addr_d = mem_addr_q;
        if (!mem_req_d && state_d == RUN && fetch_en_i && int'(outst_d) < MAX_OUTSTANDING &&
            int'(count_d) + int'(live_d) < DEPTH) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            stale_q      <= 1'b0;
            outst_q      <= '0;
            discard_q    <= '0;
            aq_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            stale_q      <= stale_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            aq_q         <= aq_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) mem_rvalid_i |-> outst_q != '0);
    assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full || pop);
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: directed bench with a simple in-order memory responder and consumer log.
module tb_if_prefetch_buffer;
    logic        clk = 1'b0;
    logic        rst_n, fetch_en_i, branch_i, mem_gnt_i, mem_rvalid_i, instr_ready_i;
    logic [31:0] pc_start_address_i, branch_addr_i, mem_rdata_i;
    logic        mem_req_o, instr_valid_o;
    logic [31:0] mem_addr_o, instr_rdata_o, instr_addr_o;
    logic [31:0] pend[$], got_a[$], got_d[$];
    logic [31:0] held;
    logic        resp_en;
    int          n_chk = 0, n_fail = 0, n0;
`ifdef PREFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    if_prefetch_buffer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_en_i         (fetch_en_i),
        .pc_start_address_i (pc_start_address_i),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i),
        .mem_req_o          (mem_req_o),
        .mem_addr_o         (mem_addr_o),
        .mem_gnt_i          (mem_gnt_i),
        .mem_rvalid_i       (mem_rvalid_i),
        .mem_rdata_i        (mem_rdata_i),
        .instr_valid_o      (instr_valid_o),
        .instr_rdata_o      (instr_rdata_o),
        .instr_addr_o       (instr_addr_o),
        .instr_ready_i      (instr_ready_i)
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [31:0] base, input int n);
        check({tag, "_n"}, 32'(got_a.size() >= n), 32'd1);
        for (int i = 0; i < n && i < got_a.size(); i++) begin
            check({tag, "_a"}, got_a[i], base + 32'(4 * i));
            check({tag, "_d"}, got_d[i], dat(base + 32'(4 * i)));
        end
    endtask

    // Sample at negedge, then answer the bus just after the posedge; grants answer no earlier than next cycle.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        @(negedge clk);
        g  = mem_req_o && mem_gnt_i;
        ga = mem_addr_o;
        if (instr_valid_o && instr_ready_i && !branch_i) begin
            got_a.push_back(instr_addr_o);
            got_d.push_back(instr_rdata_o);
        end
        @(posedge clk);
        #1;
        mem_rvalid_i = 1'b0;
        if (resp_en && pend.size() > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = dat(pend.pop_front());
        end
        if (g) pend.push_back(ga);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_maddr"}, mem_addr_o, 32'd0);
        check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
        check({tag, "_rdata"}, instr_rdata_o, 32'd0);
        check({tag, "_iaddr"}, instr_addr_o, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; instr_ready_i = 1'b0; resp_en = 1'b0;
        pc_start_address_i = '0; branch_addr_i = '0; mem_rdata_i = '0;
        tick();
        check_zero("rst");
        tick();
        rst_n = 1'b1;
        // plain streaming
        pc_start_address_i = 32'h100; fetch_en_i = 1'b1; mem_gnt_i = 1'b1;
        resp_en = 1'b1; instr_ready_i = 1'b1;
        repeat (12) tick();
        check_seq("seq", 32'h100, 3);
        // back-pressure fills exactly DEPTH
        n0 = got_a.size();
        instr_ready_i = 1'b0;
        repeat (10) tick();
        check("full_req", 32'(mem_req_o), 32'd0);
        check("full_valid", 32'(instr_valid_o), 32'd1);
        check("full_head", instr_addr_o, 32'h100 + 32'(4 * n0));
        fetch_en_i = 1'b0; instr_ready_i = 1'b1;
        repeat (8) tick();
        check("drain_cnt", 32'(got_a.size() - n0), 32'd4);
        check_seq("drain", 32'h100, got_a.size());
        // branch with queued entries and an outstanding response
        got_a.delete(); got_d.delete();
        fetch_en_i = 1'b1; instr_ready_i = 1'b0;
        repeat (5) tick();
        resp_en = 1'b0;
        tick();
        check("pre_br_valid", 32'(instr_valid_o), 32'd1);
        branch_addr_i = 32'h2002; branch_i = 1'b1;
        tick();
        branch_i = 1'b0;
        check("br_valid", 32'(instr_valid_o), 32'd0);
        resp_en = 1'b1; instr_ready_i = 1'b1;
        repeat (12) tick();
        check_seq("br", 32'h2000, 4);
        // branch while a request waits for grant
        mem_gnt_i = 1'b0;
        repeat (3) tick();
        check("hold_req", 32'(mem_req_o), 32'd1);
        held = mem_addr_o;
        tick();
        check("hold_a0", mem_addr_o, held);
        got_a.delete(); got_d.delete();
        branch_addr_i = 32'h3003; branch_i = 1'b1;
        tick();
        branch_i = 1'b0;
        repeat (3) begin
            tick();
            check("hold_a", mem_addr_o, held);
            check("hold_r", 32'(mem_req_o), 32'd1);
        end
        mem_gnt_i = 1'b1;
        tick();
        check("new_req", 32'(mem_req_o), 32'd1);
        check("new_addr", mem_addr_o, 32'h3000);
        repeat (12) tick();
        check_seq("rd", 32'h3000, 4);
        // address wrap, then asynchronous reset mid-burst
        pc_start_address_i = 32'hFFFF_FFF8;
        rst_n = 1'b0; mem_rvalid_i = 1'b0; pend.delete();
        tick(); tick();
        rst_n = 1'b1;
        got_a.delete(); got_d.delete();
        repeat (12) tick();
        check_seq("wrap", 32'hFFFF_FFF8, 3);
        #2;
        rst_n = 1'b0; mem_rvalid_i = 1'b0; pend.delete();
        #1;
        check_zero("arst");
        fetch_en_i = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("boot_req", 32'(mem_req_o), 32'd0);
        // outstanding limit and response latency
        got_a.delete(); got_d.delete();
        pc_start_address_i = 32'h40; fetch_en_i = 1'b1; resp_en = 1'b0;
        repeat (5) tick();
        check("max_os_req", 32'(mem_req_o), 32'd0);
        check("idle_valid", 32'(instr_valid_o), 32'd0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        void'(pend.pop_front());
        #1;
        check("lat0_valid", 32'(instr_valid_o), 32'(BYP));
        tick();
        check("lat1_valid", 32'(instr_valid_o), 32'(!BYP));
        tick();
        check("lat_cnt", 32'(got_a.size()), 32'd1);
        if (got_a.size() >= 1) begin
            check("lat_addr", got_a[0], 32'h40);
            check("lat_data", got_d[0], 32'h0000_0013);
        end
        resp_en = 1'b1;
        repeat (6) tick();
        check("tail_n", 32'(got_a.size() >= 2), 32'd1);
        if (got_a.size() >= 2) begin
            check("tail_a", got_a[1], 32'h44);
            check("tail_d", got_d[1], dat(32'h44));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
